// File: rtl/key_debounce_encoder_pkg.sv
// Shared constants and types for the piano key input stage.
package key_debounce_encoder_pkg;

  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned NUM_KEYS = 8;

  typedef logic [NOTE_W-1:0] note_code_t;

  localparam note_code_t NOTE_SILENT = 4'd0;

  typedef struct packed {
    note_code_t code;
    logic       octave;
  } note_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_debounce_encoder_if.sv
// Raw switch inputs and conditioned note outputs of the key input stage.
interface key_debounce_encoder_if;
  import key_debounce_encoder_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic                octave_raw;
  logic [NUM_KEYS-1:0] key_stable;
  note_code_t          note_code;
  logic                note_octave;
  logic                note_valid;
  logic                multi_press;

  modport master (
    output key_raw, octave_raw,
    input  key_stable, note_code, note_octave, note_valid, multi_press
  );

  modport slave (
    input  key_raw, octave_raw,
    output key_stable, note_code, note_octave, note_valid, multi_press
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One switch input: 2-flop synchroniser followed by a stable-time debouncer.
module key_debounce_cell #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable
);

  localparam int unsigned    CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Any return of the synchronised input to the stable value restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/key_debounce_encoder.sv
// Debounces the note keys and octave switch, priority-encodes the lowest
// pressed key into a registered note code and strobes on every note change.
module key_debounce_encoder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned NUM_KEYS    = key_debounce_encoder_pkg::NUM_KEYS
) (
  input  logic                   clk,
  input  logic                   rst,
  key_debounce_encoder_if.slave  kb
);
  import key_debounce_encoder_pkg::*;

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

  logic [NUM_KEYS:0] w_raw;
  logic [NUM_KEYS:0] w_stable;
  note_t             w_next;
  logic              w_multi;
  note_t             r_note;
  logic              r_valid;
  logic              r_multi;

  // Bit NUM_KEYS carries the octave switch through the same cell as the keys.
  assign w_raw = {kb.octave_raw, kb.key_raw};

  for (genvar g = 0; g <= NUM_KEYS; g++) begin : g_cell
    key_debounce_cell #(
      .DB_CYCLES (DB_CYCLES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (w_raw[g]),
      .o_stable (w_stable[g])
    );
  end

  always_comb begin
    w_next.code   = NOTE_SILENT;
    w_next.octave = w_stable[NUM_KEYS];
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (w_stable[i-1]) begin
        w_next.code = NOTE_W'(i);
      end
    end
    w_multi = ($countones(w_stable[NUM_KEYS-1:0]) > 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_note  <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_note  <= w_next;
      r_valid <= (w_next != r_note);
      r_multi <= w_multi;
    end
  end

  assign kb.key_stable  = w_stable[NUM_KEYS-1:0];
  assign kb.note_code   = r_note.code;
  assign kb.note_octave = r_note.octave;
  assign kb.note_valid  = r_valid;
  assign kb.multi_press = r_multi;

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Self-checking bench for key_debounce_encoder with a 4-cycle debounce time.
module tb_key_debounce_encoder;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned DB_MS  = 4;
  localparam int unsigned DB     = CLK_HZ / 1000 * DB_MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  key_debounce_encoder_if bus ();

  key_debounce_encoder #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DB_MS),
    .NUM_KEYS    (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .kb  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [14:0] dut_out();
    return {bus.key_stable, bus.note_code, bus.note_octave, bus.note_valid, bus.multi_press};
  endfunction

  // Lowest pressed key index + 1, via isolating the lowest set bit.
  function automatic logic [3:0] enc(input logic [7:0] k);
    logic [7:0] lsb;
    if (k == 8'd0) return 4'd0;
    lsb = k & (~k + 8'd1);
    return 4'($clog2(lsb) + 1);
  endfunction

  // Reference: input is 2 edges late; a bit flips once the last DB samples all disagree.
  logic [8:0] m_d1, m_sync, m_stable;
  logic [8:0] m_hist [DB-1];
  logic [3:0] m_code;
  logic       m_oct, m_valid, m_multi;

  function automatic logic [8:0] accept_mask();
    logic [8:0] d;
    d = m_sync ^ m_stable;
    for (int j = 0; j < int'(DB) - 1; j++) d &= m_hist[j] ^ m_stable;
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 <= '0; m_sync <= '0; m_stable <= '0;
      for (int j = 0; j < int'(DB) - 1; j++) m_hist[j] <= '0;
      m_code <= '0; m_oct <= 1'b0; m_valid <= 1'b0; m_multi <= 1'b0;
    end else begin
      m_d1    <= {bus.octave_raw, bus.key_raw};
      m_sync  <= m_d1;
      m_hist[0] <= m_sync;
      for (int j = 1; j < int'(DB) - 1; j++) m_hist[j] <= m_hist[j-1];
      m_stable <= m_stable ^ accept_mask();
      m_code  <= enc(m_stable[7:0]);
      m_oct   <= m_stable[8];
      m_valid <= ({enc(m_stable[7:0]), m_stable[8]} != {m_code, m_oct});
      m_multi <= ($countones(m_stable[7:0]) > 1);
    end
  end

  typedef struct {
    logic [7:0] key;
    logic       oct;
    logic [3:0] code;
    logic       exp_oct;
    logic       multi;
    int         strobes;
  } vec_t;

  vec_t vecs [10];
  int   bad;
  int   strobes;

  initial begin
    vecs[0] = '{8'h01, 1'b0, 4'd1, 1'b0, 1'b0, 1};
    vecs[1] = '{8'h05, 1'b0, 4'd1, 1'b0, 1'b1, 0};
    vecs[2] = '{8'h04, 1'b0, 4'd3, 1'b0, 1'b0, 1};
    vecs[3] = '{8'h02, 1'b1, 4'd2, 1'b1, 1'b0, 1};
    vecs[4] = '{8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1};
    vecs[5] = '{8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1};
    vecs[6] = '{8'h80, 1'b0, 4'd8, 1'b0, 1'b0, 1};
    vecs[7] = '{8'hFF, 1'b0, 4'd1, 1'b0, 1'b1, 1};
    vecs[8] = '{8'hF0, 1'b1, 4'd5, 1'b1, 1'b1, 1};
    vecs[9] = '{8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1};

    bus.key_raw    = 8'h00;
    bus.octave_raw = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_out()), 32'd0);
    rst = 1'b0;

    // Clean press: stable after 6 edges, note and strobe after 7.
    bus.key_raw = 8'h01;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 5) check("press_stable_e5", 32'(bus.key_stable), 32'h00);
      if (n == 6) begin
        check("press_stable_e6", 32'(bus.key_stable), 32'h01);
        check("press_code_e6", 32'(bus.note_code), 32'd0);
      end
      if (n == 7) check("press_note_e7", 32'({bus.note_code, bus.note_valid}), 32'({4'd1, 1'b1}));
      if (n == 8) check("press_valid_e8", 32'(bus.note_valid), 32'd0);
    end

    // Bounce on key 2 shorter than the debounce time must be ignored.
    bad = 0;
    for (int c = 0; c < 28; c++) begin
      bus.key_raw = (c < 20 && ((c / 2) % 2 == 0)) ? 8'h05 : 8'h01;
      @(negedge clk);
      if (bus.key_stable !== 8'h01 || bus.note_code !== 4'd1 || bus.note_valid !== 1'b0) bad++;
    end
    check("bounce_ignored", 32'(bad), 32'd0);

    // Reset mid-count clears everything at once and stays quiet afterwards.
    bus.key_raw = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_mid_count", 32'(dut_out()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dut_out() !== 15'd0) bad++;
    end
    check("quiet_after_reset", 32'(bad), 32'd0);

    for (int v = 0; v < 10; v++) begin
      bus.key_raw    = vecs[v].key;
      bus.octave_raw = vecs[v].oct;
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.note_valid === 1'b1) strobes++;
      end
      check($sformatf("vec%0d_out", v), 32'(dut_out()),
            32'({vecs[v].key, vecs[v].code, vecs[v].exp_oct, 1'b0, vecs[v].multi}));
      check($sformatf("vec%0d_strobes", v), 32'(strobes), 32'(vecs[v].strobes));
    end

    for (int s = 0; s < 80; s++) begin
      logic [7:0] k;
      logic       o;
      int unsigned hold;
      k    = 8'($urandom & $urandom);
      o    = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      bus.key_raw    = k;
      bus.octave_raw = o;
      for (int unsigned h = 0; h < hold; h++) begin
        @(negedge clk);
        check("random_vs_model", 32'(dut_out()),
              32'({m_stable[7:0], m_code, m_oct, m_valid, m_multi}));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
